// File: rtl/logic_arbiter_pkg.sv
// Shared opcode and FSM encodings for the round-robin logic-unit arbiter.
package logic_arbiter_pkg;

    localparam int unsigned OPW = 2;

    typedef enum logic [OPW-1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Requester index width, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise AND/OR/XOR/NOR over W bits; X/Z propagate naturally.
module logic_unit
    import logic_arbiter_pkg::*;
#(
    parameter int unsigned W = 8
)(
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y
);

    always_comb begin
        y = ~(a | b);
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logic_unit among N requesters, with a
// valid/ready result handshake and a completed-operation counter.
module logic_arbiter
    import logic_arbiter_pkg::*;
#(
    parameter  int unsigned W  = 8,
    parameter  int unsigned N  = 4,
    parameter  int unsigned CW = 16,
    localparam int unsigned IW = idx_w(N)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [2*N-1:0]    op,
    input  logic [W*N-1:0]    a,
    input  logic [W*N-1:0]    b,
    output logic [N-1:0]      gnt,
    output logic              busy,
    output logic [W-1:0]      y,
    output logic [IW-1:0]     rid,
    output logic              rvalid,
    input  logic              rready,
    output logic [CW-1:0]     done_cnt
);

    state_e          state;
    state_e          state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win_c;
    logic            win_vld_c;
    int unsigned     scan_idx;
    logic            take_c;
    logic            exec_c;
    logic            finish_c;
    logic [OPW-1:0]  op_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    lu_y;

    logic [OPW-1:0]  op_arr [N];
    logic [W-1:0]    a_arr  [N];
    logic [W-1:0]    b_arr  [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign op_arr[g] = op[OPW*g +: OPW];
        assign a_arr[g]  = a[W*g +: W];
        assign b_arr[g]  = b[W*g +: W];
    end

    // First set request bit after ptr, wrapping modulo N.
    always_comb begin
        win_c     = '0;
        win_vld_c = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            scan_idx = (32'(ptr) + k) % N;
            if (!win_vld_c && req[IW'(scan_idx)]) begin
                win_vld_c = 1'b1;
                win_c     = IW'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (win_vld_c) state_nx = S_EXEC;
            S_EXEC:  state_nx = S_DONE;
            S_DONE:  if (rready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        take_c   = 1'b0;
        exec_c   = 1'b0;
        finish_c = 1'b0;
        case (state)
            S_IDLE:  take_c   = win_vld_c;
            S_EXEC:  exec_c   = 1'b1;
            S_DONE:  finish_c = rready;
            default: ;
        endcase
    end

    logic_unit #(.W(W)) u_logic_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (lu_y)
    );

    // Datapath and handshake registers; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            busy     <= 1'b0;
            y        <= '0;
            rid      <= '0;
            rvalid   <= 1'b0;
            done_cnt <= '0;
            ptr      <= IW'(N - 1);
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            gnt  <= '0;
            busy <= (state_nx != S_IDLE);
            if (take_c) begin
                op_q <= op_arr[win_c];
                a_q  <= a_arr[win_c];
                b_q  <= b_arr[win_c];
                rid  <= win_c;
                ptr  <= win_c;
                gnt  <= N'(1) << win_c;
            end
            if (exec_c) begin
                y      <= lu_y;
                rvalid <= 1'b1;
            end
            if (finish_c) begin
                rvalid   <= 1'b0;
                done_cnt <= done_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter; a second instance with CW=2 shows counter wrap.
module tb_logic_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [2*N-1:0]   op;
    logic [W*N-1:0]   a;
    logic [W*N-1:0]   b;
    logic             rready;

    logic [N-1:0]     gnt,    gnt_w;
    logic             busy,   busy_w;
    logic [W-1:0]     y,      y_w;
    logic [1:0]       rid,    rid_w;
    logic             rvalid, rvalid_w;
    logic [15:0]      done_cnt;
    logic [1:0]       done_cnt_w;

    int nvec = 0;
    int nerr = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    logic_arbiter #(.W(W), .N(N), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .busy(busy), .y(y), .rid(rid), .rvalid(rvalid),
        .rready(rready), .done_cnt(done_cnt)
    );

    logic_arbiter #(.W(W), .N(N), .CW(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt_w), .busy(busy_w), .y(y_w), .rid(rid_w), .rvalid(rvalid_w),
        .rready(rready), .done_cnt(done_cnt_w)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic set_opnd(input int i, input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb);
        op[2*i +: 2] = o;
        a[8*i +: 8]  = va;
        b[8*i +: 8]  = vb;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output logic to);
        to = 1'b1;
        g  = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (gnt != '0) begin
                g  = gnt;
                to = 1'b0;
                break;
            end
        end
    endtask

    // Full transaction with rready high; granted requester drops req after gnt.
    task automatic txn(input logic [N-1:0] r, output logic [N-1:0] g,
                       output logic [7:0] yv, output logic [1:0] rv, output logic to);
        req = r;
        wait_gnt(g, to);
        req = r & ~g;
        yv = '0;
        rv = '0;
        if (to) begin
            req = '0;
            return;
        end
        to = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rvalid) begin
                to = 1'b0;
                break;
            end
        end
        yv = y;
        rv = rid;
        if (!to) begin
            @(posedge clk); #1;
            exp_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; op = '0; a = '0; b = '0; rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        nvec++; if (y !== 8'h00) begin nerr++; $display("FAIL reset_y got %h want 00", y); end
        nvec++; if (rid !== 2'd0) begin nerr++; $display("FAIL reset_rid got %0d want 0", rid); end
        nvec++; if (rvalid !== 1'b0) begin nerr++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        nvec++; if (done_cnt !== 16'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", done_cnt); end
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_single();
        logic [N-1:0] g;
        logic to;
        set_opnd(0, 2'b01, 8'hF0, 8'h0F);
        req = 4'b0001;
        wait_gnt(g, to);
        req = '0;
        nvec++; if (to || g !== 4'b0001) begin nerr++; $display("FAIL single_gnt got %b timeout %b want 0001", g, to); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy got %b want 1", busy); end
        @(posedge clk); #1;
        nvec++; if (gnt !== 4'b0000) begin nerr++; $display("FAIL single_gnt_pulse got %b want 0000", gnt); end
        nvec++; if (rvalid !== 1'b1) begin nerr++; $display("FAIL single_rvalid got %b want 1", rvalid); end
        nvec++; if (y !== 8'hFF) begin nerr++; $display("FAIL single_y got %h want ff", y); end
        nvec++; if (rid !== 2'd0) begin nerr++; $display("FAIL single_rid got %0d want 0", rid); end
        @(posedge clk); #1;
        exp_cnt = 1;
        nvec++; if (rvalid !== 1'b0) begin nerr++; $display("FAIL single_rvalid_drop got %b want 0", rvalid); end
        nvec++; if (done_cnt !== 16'd1) begin nerr++; $display("FAIL single_cnt got %0d want 1", done_cnt); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_opcodes();
        logic [7:0] expv [4];
        logic [N-1:0] g;
        logic [7:0] yv;
        logic [1:0] rv;
        logic to;
        expv[0] = 8'hA0; expv[1] = 8'hFA; expv[2] = 8'h5A; expv[3] = 8'h05;
        for (int i = 0; i < 4; i++) begin
            set_opnd(2, 2'(i), 8'hF0, 8'hAA);
            txn(4'b0100, g, yv, rv, to);
            nvec++; if (to || g !== 4'b0100) begin nerr++; $display("FAIL opc%0d_gnt got %b timeout %b want 0100", i, g, to); end
            nvec++; if (yv !== expv[i]) begin nerr++; $display("FAIL opc%0d_y got %h want %h", i, yv, expv[i]); end
            nvec++; if (rv !== 2'd2) begin nerr++; $display("FAIL opc%0d_rid got %0d want 2", i, rv); end
        end
        req = '0;
        nvec++; if (done_cnt !== 16'(exp_cnt)) begin nerr++; $display("FAIL opc_cnt got %0d want %0d", done_cnt, exp_cnt); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] g;
        logic [N-1:0] rem;
        logic [7:0] yv;
        logic [1:0] rv;
        logic to;
        logic [N-1:0] want;
        for (int i = 0; i < 4; i++) set_opnd(i, 2'b10, 8'(8'h11 * i), 8'hFF);
        // Park the pointer on requester 3.
        txn(4'b1000, g, yv, rv, to);
        nvec++; if (to || g !== 4'b1000) begin nerr++; $display("FAIL rr_park got %b want 1000", g); end
        rem = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            want = 4'(1 << k);
            txn(rem, g, yv, rv, to);
            rem = rem & ~g;
            nvec++; if (to || g !== want) begin nerr++; $display("FAIL rr_order%0d got %b want %b", k, g, want); end
            nvec++; if (yv !== ~8'(8'h11 * k)) begin nerr++; $display("FAIL rr_y%0d got %h want %h", k, yv, ~8'(8'h11 * k)); end
        end
        txn(4'b1001, g, yv, rv, to);
        nvec++; if (to || g !== 4'b0001) begin nerr++; $display("FAIL rr_wrap0 got %b want 0001", g); end
        txn(4'b1001, g, yv, rv, to);
        nvec++; if (to || g !== 4'b1000) begin nerr++; $display("FAIL rr_wrap3 got %b want 1000", g); end
        nvec++; if (rv !== 2'd3) begin nerr++; $display("FAIL rr_wrap3_rid got %0d want 3", rv); end
        txn(4'b1001, g, yv, rv, to);
        nvec++; if (to || g !== 4'b0001) begin nerr++; $display("FAIL rr_wrap_again got %b want 0001", g); end
        req = '0;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] g;
        logic to;
        rready = 1'b0;
        set_opnd(0, 2'b10, 8'h3C, 8'hFF);
        req = 4'b0001;
        wait_gnt(g, to);
        req = '0;
        nvec++; if (to || g !== 4'b0001) begin nerr++; $display("FAIL bp_gnt got %b want 0001", g); end
        set_opnd(0, 2'b00, 8'h00, 8'h00);
        @(posedge clk); #1;
        nvec++; if (rvalid !== 1'b1 || y !== 8'hC3) begin nerr++; $display("FAIL bp_result got rvalid %b y %h want 1 c3", rvalid, y); end
        for (int c = 0; c < 5; c++) begin
            set_opnd(0, 2'b01, 8'($urandom_range(255)), 8'($urandom_range(255)));
            @(posedge clk); #1;
            nvec++;
            if (rvalid !== 1'b1 || y !== 8'hC3 || rid !== 2'd0 || busy !== 1'b1 || done_cnt !== 16'(exp_cnt)) begin
                nerr++;
                $display("FAIL bp_hold%0d got rvalid %b y %h rid %0d busy %b cnt %0d want 1 c3 0 1 %0d",
                         c, rvalid, y, rid, busy, done_cnt, exp_cnt);
            end
        end
        rready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        nvec++; if (rvalid !== 1'b0) begin nerr++; $display("FAIL bp_release got %b want 0", rvalid); end
        nvec++; if (done_cnt !== 16'(exp_cnt)) begin nerr++; $display("FAIL bp_cnt got %0d want %0d", done_cnt, exp_cnt); end
        repeat (3) @(posedge clk); #1;
        nvec++; if (done_cnt !== 16'(exp_cnt)) begin nerr++; $display("FAIL bp_idle_ready got %0d want %0d", done_cnt, exp_cnt); end
        nvec++; if (y !== 8'hC3 || busy !== 1'b0) begin nerr++; $display("FAIL bp_y_kept got y %h busy %b want c3 0", y, busy); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g;
        logic [7:0] yv;
        logic [1:0] rv;
        logic to;
        set_opnd(0, 2'b01, 8'h55, 8'hAA);
        req = 4'b0001;
        wait_gnt(g, to);
        req = '0;
        #1 rst_n = 1'b0;
        #1;
        nvec++; if (rvalid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin nerr++; $display("FAIL rstmid_ctl got rvalid %b busy %b gnt %b want 0 0 0000", rvalid, busy, gnt); end
        nvec++; if (y !== 8'h00 || done_cnt !== 16'd0) begin nerr++; $display("FAIL rstmid_data got y %h cnt %0d want 00 0", y, done_cnt); end
        exp_cnt = 0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        set_opnd(1, 2'b00, 8'h0F, 8'h3C);
        txn(4'b0010, g, yv, rv, to);
        nvec++; if (to || g !== 4'b0010) begin nerr++; $display("FAIL rstmid_gnt got %b want 0010", g); end
        nvec++; if (yv !== 8'h0C || rv !== 2'd1) begin nerr++; $display("FAIL rstmid_y got %h rid %0d want 0c 1", yv, rv); end
        nvec++; if (done_cnt !== 16'd1 || done_cnt_w !== 2'd1) begin nerr++; $display("FAIL rstmid_cnt got %0d/%0d want 1/1", done_cnt, done_cnt_w); end
        req = '0;
    endtask

    task automatic test_x_and_wrap();
        logic [N-1:0] g;
        logic [7:0] yv;
        logic [1:0] rv;
        logic to;
        logic [7:0] xa, xb, expv;
        xa = 8'hxx;
        xb = 8'hxx;
        expv = xa | xb;
        set_opnd(3, 2'b01, xa, xb);
        txn(4'b1000, g, yv, rv, to);
        nvec++; if (to || g !== 4'b1000) begin nerr++; $display("FAIL x_gnt got %b timeout %b want 1000", g, to); end
        nvec++; if (yv !== expv) begin nerr++; $display("FAIL x_y got %h want %h", yv, expv); end
        set_opnd(0, 2'b00, 8'hFF, 8'h81);
        while ((exp_cnt % 4) != 3) txn(4'b0001, g, yv, rv, to);
        nvec++; if (done_cnt_w !== 2'd3) begin nerr++; $display("FAIL wrap_pre got %0d want 3", done_cnt_w); end
        txn(4'b0001, g, yv, rv, to);
        nvec++; if (to || yv !== 8'h81) begin nerr++; $display("FAIL wrap_y got %h want 81", yv); end
        nvec++; if (done_cnt_w !== 2'd0) begin nerr++; $display("FAIL wrap_cnt got %0d want 0", done_cnt_w); end
        nvec++; if (done_cnt !== 16'(exp_cnt)) begin nerr++; $display("FAIL wrap_full_cnt got %0d want %0d", done_cnt, exp_cnt); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_opcodes();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_x_and_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
